// File: rtl/sample_fetch_if.sv
// sample_fetch_if: run request, upstream address handshake, memory read port and output stream
interface sample_fetch_if #(parameter int DATA_W = 16);
  logic start;
  logic [13:0] addr_in;
  logic ack;
  logic [13:0] mem_addr;
  logic mem_rd;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic out_last;
  logic done;
  modport master(output start, addr_in, mem_rdata, out_ready,
                 input ack, mem_addr, mem_rd, out_data, out_valid, out_last, done);
  modport slave(input start, addr_in, mem_rdata, out_ready,
                output ack, mem_addr, mem_rd, out_data, out_valid, out_last, done);
endinterface

// File: rtl/sample_fetch.sv
// sample_fetch: reads N_SAMPLES words from memory through a 2-entry credit-managed buffer onto a ready/valid stream
module sample_fetch #(
  parameter int DATA_W = 16,
  parameter int N_SAMPLES = 16384
) (
  input logic clk,
  input logic rstx,
  sample_fetch_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [14:0] fetch_cnt;
  logic inflight, inflight_last;
  logic [1:0] occ;
  logic [DATA_W-1:0] d0, d1;
  logic l0, l1;
  logic pop, ack, last_rd;
  logic [1:0] slot;
  // slot is where an arriving word lands after this cycle's pop has shifted the buffer
  always_comb begin
    pop = (occ != 2'd0) && bus.out_ready;
    ack = (state == RUN) && (fetch_cnt < 15'(N_SAMPLES)) && ((occ + 2'(inflight) < 2'd2) || pop);
    last_rd = ack && (fetch_cnt == 15'(N_SAMPLES - 1));
    slot = occ - 2'(pop);
  end
  assign bus.ack = ack;
  assign bus.mem_rd = ack;
  assign bus.mem_addr = bus.addr_in;
  assign bus.out_data = d0;
  assign bus.out_valid = occ != 2'd0;
  assign bus.out_last = (occ != 2'd0) && l0;
  assign bus.done = state == DONE;
  always_ff @(posedge clk or negedge rstx)
    if (!rstx) begin
      state <= IDLE;
      fetch_cnt <= '0;
      inflight <= 1'b0;
      inflight_last <= 1'b0;
      occ <= 2'd0;
      d0 <= '0;
      d1 <= '0;
      l0 <= 1'b0;
      l1 <= 1'b0;
    end else begin
      inflight <= ack;
      inflight_last <= last_rd;
      if (ack) fetch_cnt <= fetch_cnt + 15'd1;
      occ <= occ + 2'(inflight) - 2'(pop);
      if (pop) begin
        d0 <= d1;
        l0 <= l1;
      end
      if (inflight && slot == 2'd0) begin
        d0 <= bus.mem_rdata;
        l0 <= inflight_last;
      end
      if (inflight && slot == 2'd1) begin
        d1 <= bus.mem_rdata;
        l1 <= inflight_last;
      end
      unique case (state)
        IDLE: state <= bus.start ? RUN : IDLE;
        RUN: state <= last_rd ? DRAIN : RUN;
        DRAIN: state <= (slot == 2'd0 && !inflight) ? DONE : DRAIN;
        DONE: state <= DONE;
      endcase
    end
endmodule

// File: tb/tb_sample_fetch.sv
// tb_sample_fetch: directed scenarios on a 4-sample and a 1-sample instance
module tb_sample_fetch;
  logic clk = 1'b0;
  logic rstx = 1'b0;
  always #5 clk = ~clk;
  sample_fetch_if #(.DATA_W(16)) a();
  sample_fetch_if #(.DATA_W(16)) b();
  sample_fetch #(.DATA_W(16), .N_SAMPLES(4)) u4(.clk(clk), .rstx(rstx), .bus(a.slave));
  sample_fetch #(.DATA_W(16), .N_SAMPLES(1)) u1(.clk(clk), .rstx(rstx), .bus(b.slave));
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acks = 0;
  int viol = 0;
  int donec = -1;
  int ackc[$];
  logic [15:0] got[$];
  logic lastq[$];
  logic prev_stall = 1'b0;
  logic [15:0] prev_d;
  logic prev_l;
  always @(posedge clk) cyc <= cyc + 1;
  // upstream address generators and memories returning addr+0x100 one cycle after the read
  always @(posedge clk or negedge rstx)
    if (!rstx) a.addr_in <= 14'd0;
    else if (a.ack) a.addr_in <= a.addr_in + 14'd1;
  always @(posedge clk or negedge rstx)
    if (!rstx) b.addr_in <= 14'd0;
    else if (b.ack) b.addr_in <= b.addr_in + 14'd1;
  always @(posedge clk) a.mem_rdata <= a.mem_rd ? 16'(a.mem_addr) + 16'h100 : 16'hxxxx;
  always @(posedge clk) b.mem_rdata <= b.mem_rd ? 16'(b.mem_addr) + 16'h100 : 16'hxxxx;
  always @(negedge clk)
    if (!rstx) begin
      got.delete();
      lastq.delete();
      ackc.delete();
      acks = 0;
      donec = -1;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (a.out_valid !== 1'b1 || a.out_data !== prev_d || a.out_last !== prev_l)) viol++;
      if (u4.inflight && u4.occ == 2'd2 && !(a.out_valid && a.out_ready)) viol++;
      if (u4.occ > 2'd2) viol++;
      if (a.out_valid && a.out_ready) begin
        got.push_back(a.out_data);
        lastq.push_back(a.out_last);
      end
      if (a.ack) begin
        acks++;
        ackc.push_back(cyc);
      end
      if (a.done && donec < 0) donec = cyc;
      prev_stall = a.out_valid && !a.out_ready;
      prev_d = a.out_data;
      prev_l = a.out_last;
    end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic rst_all;
    rstx = 1'b0;
    a.start = 1'b0;
    b.start = 1'b0;
    a.out_ready = 1'b0;
    b.out_ready = 1'b0;
    step;
    step;
    rstx = 1'b1;
  endtask

  task automatic pulse_start;
    a.start = 1'b1;
    step;
    a.start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim && a.done !== 1'b1; i++) step;
  endtask

  task automatic test_reset;
    rstx = 1'b0;
    a.start = 1'b0;
    b.start = 1'b0;
    a.out_ready = 1'b1;
    b.out_ready = 1'b1;
    #1;
    checks++; if (a.ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", a.ack); end
    checks++; if (a.mem_rd !== 1'b0) begin failures++; $display("FAIL reset_mem_rd got=%b exp=0", a.mem_rd); end
    checks++; if (a.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", a.out_valid); end
    checks++; if (a.out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", a.out_last); end
    checks++; if (a.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", a.done); end
    checks++; if (a.out_data !== 16'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0000", a.out_data); end
    checks++; if (b.done !== 1'b0 || b.out_valid !== 1'b0) begin failures++; $display("FAIL reset_n1 got done=%b valid=%b exp=0/0", b.done, b.out_valid); end
    step;
    rstx = 1'b1;
    step;
    step;
    checks++; if (acks !== 0) begin failures++; $display("FAIL idle_no_ack got=%0d exp=0", acks); end
  endtask

  task automatic test_basic;
    int k;
    rst_all;
    a.out_ready = 1'b1;
    k = cyc;
    pulse_start;
    wait_done(20);
    step;
    checks++; if (a.done !== 1'b1) begin failures++; $display("FAIL basic_done got=%b exp=1", a.done); end
    checks++; if (acks !== 4) begin failures++; $display("FAIL basic_acks got=%0d exp=4", acks); end
    checks++; if (ackc.size() != 4 || ackc[0] !== k + 1 || ackc[3] !== k + 4) begin failures++; $display("FAIL basic_ack_cycles got first=%0d n=%0d exp first=%0d n=4 consecutive", ackc.size() > 0 ? ackc[0] : -1, ackc.size(), k + 1); end
    checks++; if (donec !== k + 7) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=%0d", donec, k + 7); end
    checks++; if (got.size() != 4) begin failures++; $display("FAIL basic_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++; if (got[i] !== 16'(16'h100 + i) || lastq[i] !== (i == 3)) begin failures++; $display("FAIL basic_sample%0d got=%h/%b exp=%h/%b", i, got[i], lastq[i], 16'(16'h100 + i), i == 3); end
    end
  endtask

  task automatic test_stall;
    rst_all;
    pulse_start;
    for (int i = 0; i < 10; i++) step;
    checks++; if (acks !== 2) begin failures++; $display("FAIL stall_acks got=%0d exp=2", acks); end
    checks++; if (a.out_valid !== 1'b1 || a.out_data !== 16'h100) begin failures++; $display("FAIL stall_head got=%b/%h exp=1/0100", a.out_valid, a.out_data); end
    checks++; if (a.ack !== 1'b0) begin failures++; $display("FAIL stall_ack_low got=%b exp=0", a.ack); end
    a.out_ready = 1'b1;
    wait_done(20);
    step;
    checks++; if (acks !== 4 || got.size() != 4) begin failures++; $display("FAIL stall_resume got acks=%0d n=%0d exp=4/4", acks, got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++; if (got[i] !== 16'(16'h100 + i)) begin failures++; $display("FAIL stall_sample%0d got=%h exp=%h", i, got[i], 16'(16'h100 + i)); end
    end
    checks++; if (viol !== 0) begin failures++; $display("FAIL stall_stability got=%0d exp=0", viol); end
  endtask

  task automatic test_toggle;
    rst_all;
    pulse_start;
    for (int i = 0; i < 40 && a.done !== 1'b1; i++) begin
      a.out_ready = (i % 2 == 0);
      step;
    end
    a.out_ready = 1'b0;
    step;
    checks++; if (a.done !== 1'b1 || got.size() != 4 || acks !== 4) begin failures++; $display("FAIL toggle_run got done=%b n=%0d acks=%0d exp=1/4/4", a.done, got.size(), acks); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++; if (got[i] !== 16'(16'h100 + i) || lastq[i] !== (i == 3)) begin failures++; $display("FAIL toggle_sample%0d got=%h/%b exp=%h/%b", i, got[i], lastq[i], 16'(16'h100 + i), i == 3); end
    end
    checks++; if (viol !== 0) begin failures++; $display("FAIL toggle_overflow got=%0d exp=0", viol); end
  endtask

  task automatic test_single;
    int n_ack, n_out;
    logic [15:0] d;
    logic l;
    rst_all;
    b.out_ready = 1'b1;
    n_ack = 0;
    n_out = 0;
    d = 16'h0;
    l = 1'b0;
    b.start = 1'b1;
    step;
    b.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (b.ack) n_ack++;
      if (b.out_valid && b.out_ready) begin
        n_out++;
        d = b.out_data;
        l = b.out_last;
      end
      step;
    end
    checks++; if (n_ack !== 1) begin failures++; $display("FAIL single_acks got=%0d exp=1", n_ack); end
    checks++; if (n_out !== 1 || d !== 16'h100 || l !== 1'b1) begin failures++; $display("FAIL single_out got n=%0d d=%h last=%b exp=1/0100/1", n_out, d, l); end
    checks++; if (b.done !== 1'b1) begin failures++; $display("FAIL single_done got=%b exp=1", b.done); end
  endtask

  task automatic test_midreset;
    rst_all;
    a.out_ready = 1'b1;
    pulse_start;
    for (int i = 0; i < 10 && acks < 2; i++) step;
    rstx = 1'b0;
    #1;
    checks++; if (a.ack !== 1'b0 || a.mem_rd !== 1'b0 || a.done !== 1'b0) begin failures++; $display("FAIL midrst_ctrl got ack=%b rd=%b done=%b exp=0/0/0", a.ack, a.mem_rd, a.done); end
    checks++; if (a.out_valid !== 1'b0 || a.out_last !== 1'b0 || a.out_data !== 16'h0) begin failures++; $display("FAIL midrst_out got v=%b l=%b d=%h exp=0/0/0000", a.out_valid, a.out_last, a.out_data); end
    step;
    step;
    rstx = 1'b1;
    for (int i = 0; i < 4; i++) step;
    checks++; if (acks !== 0) begin failures++; $display("FAIL midrst_no_ack got=%0d exp=0", acks); end
    pulse_start;
    wait_done(20);
    step;
    checks++; if (a.done !== 1'b1 || acks !== 4 || got.size() != 4) begin failures++; $display("FAIL midrst_rerun got done=%b acks=%0d n=%0d exp=1/4/4", a.done, acks, got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++; if (got[i] !== 16'(16'h100 + i)) begin failures++; $display("FAIL midrst_sample%0d got=%h exp=%h", i, got[i], 16'(16'h100 + i)); end
    end
  endtask

  task automatic test_start_ignore;
    rst_all;
    a.out_ready = 1'b1;
    pulse_start;
    step;
    pulse_start;
    wait_done(20);
    step;
    checks++; if (acks !== 4) begin failures++; $display("FAIL start_in_run got acks=%0d exp=4", acks); end
    pulse_start;
    for (int i = 0; i < 5; i++) step;
    checks++; if (acks !== 4 || a.done !== 1'b1) begin failures++; $display("FAIL start_in_done got acks=%0d done=%b exp=4/1", acks, a.done); end
  endtask

  initial begin
    a.start = 1'b0;
    b.start = 1'b0;
    a.out_ready = 1'b0;
    b.out_ready = 1'b0;
    test_reset;
    test_basic;
    test_stall;
    test_toggle;
    test_single;
    test_midreset;
    test_start_ignore;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sample_fetch.md
SAMPLE_FETCH -- requirements
Module: sample_fetch

Interface
REQ-001 Parameters: DATA_W, default 16, sample width; N_SAMPLES, default 16384, samples fetched per run (range 1..16384).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rstx  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  single-cycle run request, honoured only in IDLE.
REQ-005 addr_in  input  14  current address from the upstream address generator; advances one cycle after each ack.
REQ-006 ack  output  1  address consumed this cycle; combinational from registered state and out_ready.
REQ-007 mem_addr  output  14  memory read address; equals addr_in.
REQ-008 mem_rd  output  1  memory read strobe; equals ack.
REQ-009 mem_rdata  input  DATA_W  read data, valid exactly 1 cycle after mem_rd.
REQ-010 out_data  output  DATA_W  head-of-buffer sample.
REQ-011 out_valid  output  1  out_data valid.
REQ-012 out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
REQ-013 out_last  output  1  high with out_valid on sample N_SAMPLES-1 only.
REQ-014 done  output  1  run complete, sticky.

Function
REQ-015 FSM states IDLE, RUN, DRAIN, DONE; IDLE -> RUN on start; RUN -> DRAIN in the cycle after the N_SAMPLES-th ack; DRAIN -> DONE when buffer empty and no read in flight; DONE held until rstx.
REQ-016 Buffer: 2-entry FIFO of {data, last}; write on registered mem_rd (in-flight flag), pop on out_valid && out_ready.
REQ-017 credit = 2 - occupancy - inflight; ack = (state==RUN) && (fetch_cnt < N_SAMPLES) && (credit > 0 || (out_valid && out_ready)).
REQ-018 ack never asserted in IDLE, DRAIN or DONE; exactly N_SAMPLES acks per run.
REQ-019 fetch_cnt: 15-bit, +1 per ack, no wrap; last tag set on the read issued when fetch_cnt == N_SAMPLES-1.
REQ-020 Latency: ack in cycle t -> sample in FIFO end of t+1 -> out_valid earliest in t+2.
REQ-021 Throughput: with out_ready held high, ack asserted every cycle of RUN after the first; one sample per cycle at output.
REQ-022 Simultaneous write and pop in the same cycle: occupancy unchanged, ordering preserved.
REQ-023 FIFO never overflows: write with occupancy 2 and no pop is impossible by REQ-017; bench asserts this.
REQ-024 out_data, out_last stable while out_valid && !out_ready.
REQ-025 start in RUN, DRAIN or DONE ignored.
REQ-026 done = 1 iff state==DONE.

Reset
REQ-027 rstx low: state IDLE, fetch_cnt 0, occupancy 0, inflight 0, ack 0, mem_rd 0, out_valid 0, out_last 0, done 0, out_data 0; takes effect immediately, mid-run included, in-flight read discarded.
REQ-028 After rstx release, no ack until a new start.

Verification
REQ-029 N_SAMPLES=4, mem_rdata = addr+16'h100, out_ready=1, start at cycle 0 -> acks on 4 consecutive cycles, outputs 0x100..0x103, out_last only on 0x103, done 1 three cycles after last ack.
REQ-030 N_SAMPLES=4, out_ready=0 throughout -> exactly 2 acks, out_valid=1 with out_data 0x100 stable, no further ack; out_ready raised -> remaining samples delivered in order.
REQ-031 N_SAMPLES=4, out_ready toggled 1,0,1,0 -> sample sequence 0x100..0x103 unchanged, no drop or duplicate, occupancy never exceeds 2.
REQ-032 N_SAMPLES=1 -> single ack, single output 0x100 with out_last=1, done=1.
REQ-033 rstx pulsed low mid-RUN after 2 acks -> all outputs at reset values same cycle; fresh start after release yields full 4-sample run.
REQ-034 start pulsed in DONE and in RUN -> no extra ack, done stays 1 in DONE.
